// File: rtl/tmr_pkg.sv
// Shared constants and types for the timer status block.
//   CNT_MAX / CNT_MIN : wrap boundary values at the default 8-bit counter width
//   TSR_*_BIT         : flag bit positions in the timer status register
//   tmr_evt_t         : one-cycle wrap events {ovf, udf}
package tmr_pkg;

  localparam logic [7:0] CNT_MAX = 8'hFF;
  localparam logic [7:0] CNT_MIN = 8'h00;

  localparam int unsigned TSR_OVF_BIT = 0;
  localparam int unsigned TSR_UDF_BIT = 1;

  typedef struct packed {
    logic ovf;
    logic udf;
  } tmr_evt_t;

endpackage

// File: rtl/tmr_status_wrap_det.sv
// Wrap detector for the timer counter.
// Registers the counter's control inputs so they line up with the cnt/last_cnt pair that the
// counter produced on the same edge, then compares that pair against the wrap boundaries.
// Ports:
//   clk_in, preset             : clock, synchronous active-high reset
//   en, ud, load, count_enable : counter controls (same signals that drive the counter)
//   cnt, last_cnt              : counter value now and one cycle earlier
//   evt                        : combinational overflow/underflow event for this cycle
module tmr_status_wrap_det
  import tmr_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             preset,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] last_cnt,
  output tmr_evt_t         evt
);

  // Boundaries at the configured width; at CNT_W = 8 these equal CNT_MIN and CNT_MAX.
  localparam logic [CNT_W-1:0] WrapMin = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] WrapMax = ~WrapMin;

  logic en_q, ud_q, load_q, ce_q;

  always_ff @(posedge clk_in) begin
    if (preset) begin
      en_q   <= 1'b0;
      ud_q   <= 1'b0;
      load_q <= 1'b0;
      ce_q   <= 1'b0;
    end else begin
      en_q   <= en;
      ud_q   <= ud;
      load_q <= load;
      ce_q   <= count_enable;
    end
  end

  logic counting;
  // A load that happens to produce a wrap-shaped pair must not count as a wrap.
  assign counting = en_q & ce_q & ~load_q;

  always_comb begin
    evt     = '0;
    evt.ovf = counting & ~ud_q & (last_cnt == WrapMax) & (cnt == WrapMin);
    evt.udf = counting &  ud_q & (last_cnt == WrapMin) & (cnt == WrapMax);
  end

endmodule

// File: rtl/tmr_status.sv
// Timer status/interrupt block: sticky overflow/underflow flags (W1C), registered level
// interrupt and an optional saturating overrun event counter.
// Optional feature macro: TMR_EVT_CNT_EN enables evt_cnt; without it evt_cnt is tied to 0
// and clr_evt is ignored.
// Ports:
//   clk_in, preset             : clock, synchronous active-high reset
//   en, ud, load, count_enable : counter controls
//   cnt, last_cnt              : counter value now and one cycle earlier
//   clr_ovf, clr_udf           : write-1-to-clear strobes for the flags
//   ovf_ie, udf_ie             : interrupt enables
//   clr_evt                    : clears evt_cnt
//   tsr_ovf, tsr_udf           : sticky flags
//   irq                        : registered level interrupt
//   evt_cnt                    : saturating overrun count
module tmr_status
  import tmr_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned EVT_W = 4
) (
  input  logic             clk_in,
  input  logic             preset,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] last_cnt,
  input  logic             clr_ovf,
  input  logic             clr_udf,
  input  logic             ovf_ie,
  input  logic             udf_ie,
  input  logic             clr_evt,
  output logic             tsr_ovf,
  output logic             tsr_udf,
  output logic             irq,
  output logic [EVT_W-1:0] evt_cnt
);

  tmr_evt_t   evt;
  logic [1:0] tsr_q;
  logic       irq_q;

  tmr_status_wrap_det #(
    .CNT_W(CNT_W)
  ) u_wrap_det (
    .clk_in       (clk_in),
    .preset       (preset),
    .en           (en),
    .ud           (ud),
    .load         (load),
    .count_enable (count_enable),
    .cnt          (cnt),
    .last_cnt     (last_cnt),
    .evt          (evt)
  );

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk_in) begin
    if (preset) begin
      tsr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      tsr_q[TSR_OVF_BIT] <= evt.ovf | (tsr_q[TSR_OVF_BIT] & ~clr_ovf);
      tsr_q[TSR_UDF_BIT] <= evt.udf | (tsr_q[TSR_UDF_BIT] & ~clr_udf);
      irq_q <= (tsr_q[TSR_OVF_BIT] & ovf_ie) | (tsr_q[TSR_UDF_BIT] & udf_ie);
    end
  end

  assign tsr_ovf = tsr_q[TSR_OVF_BIT];
  assign tsr_udf = tsr_q[TSR_UDF_BIT];
  assign irq     = irq_q;

`ifdef TMR_EVT_CNT_EN
  localparam logic [EVT_W-1:0] EvtMax = '1;

  logic             overrun;
  logic [EVT_W-1:0] evt_q;

  // An overrun is a new event arriving while its flag is still pending.
  assign overrun = (evt.ovf & tsr_q[TSR_OVF_BIT]) | (evt.udf & tsr_q[TSR_UDF_BIT]);

  always_ff @(posedge clk_in) begin
    if (preset) begin
      evt_q <= '0;
    end else if (clr_evt) begin
      evt_q <= '0;
    end else if (overrun && (evt_q != EvtMax)) begin
      evt_q <= evt_q + EVT_W'(1);
    end
  end

  assign evt_cnt = evt_q;
`else
  logic unused_clr_evt;
  assign unused_clr_evt = clr_evt;
  assign evt_cnt        = '0;
`endif

endmodule

// File: tb/tb_tmr_status.sv
// Directed self-checking bench for tmr_status. The bench plays the counter: after each rising
// edge it updates cnt/last_cnt, and the controls it holds are what the counter saw on that edge.
module tb_tmr_status;

  logic       clk_in = 1'b0;
  logic       preset, en, ud, load, count_enable;
  logic [7:0] cnt, last_cnt;
  logic       clr_ovf, clr_udf, ovf_ie, udf_ie, clr_evt;
  logic       tsr_ovf, tsr_udf, irq;
  logic [3:0] evt_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  tmr_status #(
    .CNT_W(8),
    .EVT_W(4)
  ) dut (
    .clk_in       (clk_in),
    .preset       (preset),
    .en           (en),
    .ud           (ud),
    .load         (load),
    .count_enable (count_enable),
    .cnt          (cnt),
    .last_cnt     (last_cnt),
    .clr_ovf      (clr_ovf),
    .clr_udf      (clr_udf),
    .ovf_ie       (ovf_ie),
    .udf_ie       (udf_ie),
    .clr_evt      (clr_evt),
    .tsr_ovf      (tsr_ovf),
    .tsr_udf      (tsr_udf),
    .irq          (irq),
    .evt_cnt      (evt_cnt)
  );

  // One counter edge: wait for the edge, then present the counter's new value.
  task automatic step(input logic [7:0] nc);
    @(posedge clk_in);
    #1;
    last_cnt = cnt;
    cnt      = nc;
  endtask

  task automatic edge_only();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    preset = 1'b1; en = 1'b0; ud = 1'b0; load = 1'b0; count_enable = 1'b0;
    cnt = 8'h00; last_cnt = 8'h00;
    clr_ovf = 1'b0; clr_udf = 1'b0; ovf_ie = 1'b0; udf_ie = 1'b0; clr_evt = 1'b0;
    edge_only();
    preset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    preset = 1'b1;
    en = 1'b1; count_enable = 1'b1; ovf_ie = 1'b1; last_cnt = 8'hFF; cnt = 8'h00;
    edge_only();
    edge_only();
    tests_run++;
    if (tsr_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tsr_ovf got %b want 0", tsr_ovf);
    end
    tests_run++;
    if (tsr_udf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tsr_udf got %b want 0", tsr_udf);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL reset_irq got %b want 0", irq);
    end
    tests_run++;
    if (evt_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL reset_evt_cnt got %0d want 0", evt_cnt);
    end
  endtask

  task automatic test_gating();
    do_reset();
    last_cnt = 8'hFF; cnt = 8'h00;
    en = 1'b1; count_enable = 1'b0; ud = 1'b0;
    edge_only(); edge_only();
    tests_run++;
    if (tsr_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL gate_ce_off got %b want 0", tsr_ovf);
    end
    en = 1'b0; count_enable = 1'b1;
    edge_only(); edge_only();
    tests_run++;
    if (tsr_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL gate_en_off got %b want 0", tsr_ovf);
    end
    // Up-wrap pair while counting down is not an event.
    en = 1'b1; ud = 1'b1;
    edge_only(); edge_only();
    tests_run++;
    if ({tsr_ovf, tsr_udf} !== 2'b00) begin
      tests_failed++; $display("FAIL gate_dir_mismatch got %b want 00", {tsr_ovf, tsr_udf});
    end
  endtask

  task automatic test_up_wrap();
    do_reset();
    en = 1'b1; count_enable = 1'b1; ud = 1'b0; ovf_ie = 1'b1;
    last_cnt = 8'hFC; cnt = 8'hFD;
    step(8'hFE); step(8'hFF); step(8'h00);
    step(8'h01);
    tests_run++;
    if ({tsr_ovf, irq} !== 2'b10) begin
      tests_failed++; $display("FAIL up_flag got ovf,irq=%b want 10", {tsr_ovf, irq});
    end
    step(8'h02);
    tests_run++;
    if ({tsr_ovf, irq, tsr_udf} !== 3'b110) begin
      tests_failed++; $display("FAIL up_irq got ovf,irq,udf=%b want 110", {tsr_ovf, irq, tsr_udf});
    end
    clr_ovf = 1'b1;
    step(8'h03);
    clr_ovf = 1'b0;
    tests_run++;
    if ({tsr_ovf, irq} !== 2'b01) begin
      tests_failed++; $display("FAIL up_w1c got ovf,irq=%b want 01", {tsr_ovf, irq});
    end
    step(8'h04);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL up_irq_drop got %b want 0", irq);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    en = 1'b1; count_enable = 1'b1; ud = 1'b1; ovf_ie = 1'b1; udf_ie = 1'b0;
    last_cnt = 8'h03; cnt = 8'h02;
    step(8'h01); step(8'h00); step(8'hFF);
    step(8'hFE);
    tests_run++;
    if ({tsr_udf, tsr_ovf} !== 2'b10) begin
      tests_failed++; $display("FAIL down_flag got udf,ovf=%b want 10", {tsr_udf, tsr_ovf});
    end
    step(8'hFD);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL down_irq_masked got %b want 0", irq);
    end
    udf_ie = 1'b1;
    step(8'hFC);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL down_irq_enabled got %b want 1", irq);
    end
  endtask

  task automatic test_load_suppress();
    do_reset();
    en = 1'b1; count_enable = 1'b1; ud = 1'b1; udf_ie = 1'b1;
    last_cnt = 8'h03; cnt = 8'h02;
    step(8'h01); step(8'h00);
    load = 1'b1;
    step(8'hFF);
    load = 1'b0;
    step(8'hFE);
    tests_run++;
    if (tsr_udf !== 1'b0) begin
      tests_failed++; $display("FAIL load_no_flag got %b want 0", tsr_udf);
    end
    step(8'hFD);
    tests_run++;
    if ({tsr_udf, irq} !== 2'b00) begin
      tests_failed++; $display("FAIL load_next_dec got udf,irq=%b want 00", {tsr_udf, irq});
    end
  endtask

  task automatic test_set_vs_clear();
    do_reset();
    en = 1'b1; count_enable = 1'b1; ud = 1'b0; ovf_ie = 1'b1;
    last_cnt = 8'hFD; cnt = 8'hFE;
    step(8'hFF); step(8'h00); step(8'h01);
    step(8'hFF); step(8'h00);
    clr_ovf = 1'b1;
    step(8'h01);
    tests_run++;
    if (tsr_ovf !== 1'b1) begin
      tests_failed++; $display("FAIL set_wins got %b want 1", tsr_ovf);
    end
    step(8'h02);
    clr_ovf = 1'b0;
    tests_run++;
    if ({tsr_ovf, irq} !== 2'b01) begin
      tests_failed++; $display("FAIL clear_alone got ovf,irq=%b want 01", {tsr_ovf, irq});
    end
    step(8'h03);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL clear_irq_drop got %b want 0", irq);
    end
  endtask

  task automatic test_reset_mid_event();
    do_reset();
    en = 1'b1; count_enable = 1'b1; ud = 1'b0; ovf_ie = 1'b1;
    last_cnt = 8'hFD; cnt = 8'hFE;
    step(8'hFF); step(8'h00); step(8'h01); step(8'h02);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL rst_pre_irq got %b want 1", irq);
    end
    step(8'hFF); step(8'h00);
    preset = 1'b1;
    edge_only();
    tests_run++;
    if ({tsr_ovf, irq} !== 2'b00) begin
      tests_failed++; $display("FAIL rst_mid_event got ovf,irq=%b want 00", {tsr_ovf, irq});
    end
    preset = 1'b0;
    edge_only();
    tests_run++;
    if (tsr_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL rst_first_cycle got %b want 0", tsr_ovf);
    end
    last_cnt = 8'h00; cnt = 8'h01;
    edge_only();
    tests_run++;
    if ({tsr_ovf, irq} !== 2'b00) begin
      tests_failed++; $display("FAIL rst_after got ovf,irq=%b want 00", {tsr_ovf, irq});
    end
  endtask

  // Wrap pair held every cycle: one event per edge, flag set each time, overruns counted.
  task automatic test_back_to_back();
    logic [3:0] exp4, exp15, exp1;
`ifdef TMR_EVT_CNT_EN
    exp4 = 4'd4; exp15 = 4'd15; exp1 = 4'd1;
`else
    exp4 = 4'd0; exp15 = 4'd0; exp1 = 4'd0;
`endif
    do_reset();
    en = 1'b1; count_enable = 1'b1; ud = 1'b0;
    edge_only();
    last_cnt = 8'hFF; cnt = 8'h00;
    for (int i = 0; i < 5; i++) edge_only();
    tests_run++;
    if ({tsr_ovf, evt_cnt} !== {1'b1, exp4}) begin
      tests_failed++;
      $display("FAIL b2b_5 got ovf=%b evt=%0d want ovf=1 evt=%0d", tsr_ovf, evt_cnt, exp4);
    end
    for (int i = 0; i < 12; i++) edge_only();
    tests_run++;
    if ({tsr_ovf, evt_cnt} !== {1'b1, exp15}) begin
      tests_failed++;
      $display("FAIL b2b_17 got ovf=%b evt=%0d want ovf=1 evt=%0d", tsr_ovf, evt_cnt, exp15);
    end
    for (int i = 0; i < 3; i++) edge_only();
    tests_run++;
    if (evt_cnt !== exp15) begin
      tests_failed++; $display("FAIL evt_saturate got %0d want %0d", evt_cnt, exp15);
    end
    clr_evt = 1'b1;
    edge_only();
    clr_evt = 1'b0;
    tests_run++;
    if (evt_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL evt_clear_prio got %0d want 0", evt_cnt);
    end
    edge_only();
    tests_run++;
    if (evt_cnt !== exp1) begin
      tests_failed++; $display("FAIL evt_recount got %0d want %0d", evt_cnt, exp1);
    end
    clr_ovf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_only();
      tests_run++;
      if (tsr_ovf !== 1'b1) begin
        tests_failed++; $display("FAIL b2b_set_wins[%0d] got %b want 1", i, tsr_ovf);
      end
    end
    last_cnt = 8'h00; cnt = 8'h01;
    edge_only();
    clr_ovf = 1'b0;
    tests_run++;
    if (tsr_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_clear got %b want 0", tsr_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_gating();
    test_up_wrap();
    test_down_wrap();
    test_load_suppress();
    test_set_vs_clear();
    test_reset_mid_event();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
